// File: rtl/multi_cycle_shift_unit.sv
// multi_cycle_shift_unit: iterative SLL/SRL/SRA that shifts STEP bit positions
// per cycle. It trades latency for barrel-shifter area and sits beside the
// integer unit. Result holds its value until the next accepted Start.
module multi_cycle_shift_unit #(
    parameter int XLEN    = 32,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Start,
    input  logic               Flush,
    input  logic [XLEN-1:0]    Word,
    input  logic [SHAMT_W-1:0] Shamt,
    input  logic               SignExtend,
    input  logic               ShiftRight,
    output logic               Ready,
    output logic               Done,
    output logic [XLEN-1:0]    Result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic right;
        logic arith;
    } mode_t;

    localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

    state_t             state;
    mode_t              mode;
    logic [XLEN-1:0]    acc;
    logic [SHAMT_W-1:0] count;
    logic [SHAMT_W-1:0] k;
    logic [SHAMT_W-1:0] countNext;
    logic [XLEN-1:0]    stepped;
    logic               accept;

    assign Ready  = (state != SHIFT);
    assign Done   = (state == DONE);
    assign Result = acc;
    assign accept = Start && Ready && !Flush;

    // Per-cycle step size: never shift past the remaining count, so no underflow
    always_comb begin
        k         = (count < STEP_K) ? count : STEP_K;
        countNext = count - k;
    end

    // Small shifter: selects among 0..STEP positions instead of a full barrel
    always_comb begin
        stepped = acc;
        for (int unsigned i = 1; i <= STEP; i++) begin
            if (k == SHAMT_W'(i)) begin
                if (!mode.right) begin
                    stepped = acc << i;
                end else if (mode.arith) begin
                    stepped = XLEN'($signed(acc) >>> i);
                end else begin
                    stepped = acc >> i;
                end
            end
        end
    end

    // Control FSM and datapath registers; Flush wins over Start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            mode  <= '0;
        end else if (Flush) begin
            state <= IDLE;
            count <= '0;
        end else if (accept) begin
            acc        <= Word;
            count      <= Shamt;
            mode.right <= ShiftRight;
            mode.arith <= ShiftRight & SignExtend;
            state      <= (Shamt == '0) ? DONE : SHIFT;
        end else begin
            case (state)
                SHIFT: begin
                    acc   <= stepped;
                    count <= countNext;
                    if (countNext == '0) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_shift_unit.sv
// tb_multi_cycle_shift_unit: table-driven vectors plus scoreboard on a STEP=4
// instance, and a STEP=1 instance for the full-length serial shift.
module tb_multi_cycle_shift_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // STEP=4 instance signals
    logic        Start4 = 1'b0, Flush4 = 1'b0, SignExtend4 = 1'b0, ShiftRight4 = 1'b0;
    logic [31:0] Word4 = '0;
    logic [4:0]  Shamt4 = '0;
    logic        Ready4, Done4;
    logic [31:0] Result4;

    // STEP=1 instance signals
    logic        Start1 = 1'b0, Flush1 = 1'b0, SignExtend1 = 1'b0, ShiftRight1 = 1'b0;
    logic [31:0] Word1 = '0;
    logic [4:0]  Shamt1 = '0;
    logic        Ready1, Done1;
    logic [31:0] Result1;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] sbQ[$];

    typedef struct {
        logic [31:0] word;
        logic [4:0]  shamt;
        logic        right;
        logic        sext;
        int          lat;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[11];

    multi_cycle_shift_unit #(.XLEN(32), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .Start(Start4), .Flush(Flush4),
        .Word(Word4), .Shamt(Shamt4), .SignExtend(SignExtend4), .ShiftRight(ShiftRight4),
        .Ready(Ready4), .Done(Done4), .Result(Result4)
    );

    multi_cycle_shift_unit #(.XLEN(32), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .Start(Start1), .Flush(Flush1),
        .Word(Word1), .Shamt(Shamt1), .SignExtend(SignExtend1), .ShiftRight(ShiftRight1),
        .Ready(Ready1), .Done(Done1), .Result(Result1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every Done pulse of the STEP=4 unit pops one expected result
    always @(negedge clk) begin
        if (rst_n && Done4) begin
            compared++;
            if (sbQ.size() == 0) begin
                mismatched++;
                $display("FAIL sbUnexpectedDone: got Result 0x%0h, expected no Done", Result4);
            end else begin
                logic [31:0] e;
                e = sbQ.pop_front();
                if (Result4 !== e) begin
                    mismatched++;
                    $display("FAIL sbResult: got 0x%0h, expected 0x%0h", Result4, e);
                end
            end
        end
    end

    // Counts edges until Done (sampled at negedge) starting from e0 edges already seen
    task automatic waitDone(input int e0, input int expLat, input string name);
        int edges;
        edges = e0;
        forever begin
            @(negedge clk);
            if (Done4) break;
            if (edges >= 200) break;
            @(posedge clk);
            edges++;
        end
        check(name, 64'(edges), 64'(expLat));
    endtask

    task automatic runOp(input logic [31:0] w, input logic [4:0] s, input logic r,
                         input logic se, input int expLat, input logic [31:0] expRes);
        @(negedge clk);
        check("readyBeforeStart", 64'(Ready4), 64'd1);
        Word4 = w; Shamt4 = s; ShiftRight4 = r; SignExtend4 = se; Start4 = 1'b1;
        @(posedge clk);
        sbQ.push_back(expRes);
        #1 Start4 = 1'b0;
        waitDone(1, expLat, "latency");
        @(negedge clk);
        check("donePulseOneCycle", 64'(Done4), 64'd0);
    endtask

    initial begin
        int lowCnt;
        int edges;
        bit sawDone;

        vecs[0]  = '{32'h0000_0001, 5'd31, 1'b0, 1'b0, 9, 32'h8000_0000};
        vecs[1]  = '{32'h8000_0000, 5'd4,  1'b1, 1'b1, 2, 32'hF800_0000};
        vecs[2]  = '{32'h8000_0000, 5'd4,  1'b1, 1'b0, 2, 32'h0800_0000};
        vecs[3]  = '{32'hFFFF_FFFF, 5'd6,  1'b1, 1'b0, 3, 32'h03FF_FFFF};
        vecs[4]  = '{32'h1234_5678, 5'd0,  1'b1, 1'b1, 1, 32'h1234_5678};
        vecs[5]  = '{32'h1234_5678, 5'd8,  1'b0, 1'b0, 3, 32'h3456_7800};
        vecs[6]  = '{32'h8765_4321, 5'd12, 1'b1, 1'b1, 4, 32'hFFF8_7654};
        vecs[7]  = '{32'h0000_FFFF, 5'd16, 1'b0, 1'b1, 5, 32'hFFFF_0000};
        vecs[8]  = '{32'hF000_0000, 5'd31, 1'b1, 1'b1, 9, 32'hFFFF_FFFF};
        vecs[9]  = '{32'h4000_0000, 5'd30, 1'b1, 1'b1, 9, 32'h0000_0001};
        vecs[10] = '{32'hA5A5_A5A5, 5'd3,  1'b1, 1'b0, 2, 32'h14B4_B4B4};

        // Reset state
        #1;
        check("rstReady4", 64'(Ready4), 64'd1);
        check("rstDone4", 64'(Done4), 64'd0);
        check("rstResult4", 64'(Result4), 64'd0);
        check("rstReady1", 64'(Ready1), 64'd1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // STEP=1: 1 << 31, Ready low 31 cycles, Done on 32nd edge
        @(negedge clk);
        Word1 = 32'h1; Shamt1 = 5'd31; ShiftRight1 = 1'b0; SignExtend1 = 1'b0; Start1 = 1'b1;
        @(posedge clk);
        #1 Start1 = 1'b0;
        lowCnt = 0; edges = 1;
        forever begin
            @(negedge clk);
            if (Done1) break;
            if (!Ready1) lowCnt++;
            if (edges >= 200) break;
            @(posedge clk);
            edges++;
        end
        check("step1ReadyLow", 64'(lowCnt), 64'd31);
        check("step1Latency", 64'(edges), 64'd32);
        check("step1Result", 64'(Result1), 64'h8000_0000);

        // Table-driven vectors on STEP=4
        foreach (vecs[i]) begin
            runOp(vecs[i].word, vecs[i].shamt, vecs[i].right, vecs[i].sext,
                  vecs[i].lat, vecs[i].res);
        end

        // Back-to-back: Shamt=0 then Start held in DONE
        @(negedge clk);
        Word4 = 32'h1234_5678; Shamt4 = 5'd0; ShiftRight4 = 1'b1; SignExtend4 = 1'b1; Start4 = 1'b1;
        @(posedge clk);
        sbQ.push_back(32'h1234_5678);
        #1 Word4 = 32'h1; Shamt4 = 5'd1; ShiftRight4 = 1'b0; SignExtend4 = 1'b0;
        @(negedge clk);
        check("b2bFirstDone", 64'(Done4), 64'd1);
        @(posedge clk);
        sbQ.push_back(32'h2);
        #1 Start4 = 1'b0;
        @(negedge clk);
        check("b2bNoBubble", 64'(Ready4), 64'd0);
        @(posedge clk);
        waitDone(2, 2, "b2bLatency");
        @(negedge clk);

        // Start during SHIFT is ignored
        @(negedge clk);
        Word4 = 32'h1234_5678; Shamt4 = 5'd16; ShiftRight4 = 1'b0; SignExtend4 = 1'b0; Start4 = 1'b1;
        @(posedge clk);
        sbQ.push_back(32'h5678_0000);
        #1 Word4 = 32'hFFFF_FFFF; Shamt4 = 5'd1; ShiftRight4 = 1'b1;
        @(negedge clk);
        check("midStartReady", 64'(Ready4), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 Start4 = 1'b0;
        waitDone(3, 5, "midStartLatency");
        @(negedge clk);

        // Flush on the 3rd SHIFT cycle
        @(negedge clk);
        Word4 = 32'hFFFF_FFFF; Shamt4 = 5'd28; ShiftRight4 = 1'b0; Start4 = 1'b1;
        @(posedge clk);
        #1 Start4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        Flush4 = 1'b1; Start4 = 1'b1;
        @(posedge clk);
        #1 Flush4 = 1'b0; Start4 = 1'b0;
        @(negedge clk);
        check("flushReady", 64'(Ready4), 64'd1);
        check("flushDone", 64'(Done4), 64'd0);
        sawDone = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (Done4) sawDone = 1'b1;
        end
        check("flushNoDonePulse", 64'(sawDone), 64'd0);

        // Flush beats Start in IDLE
        @(negedge clk);
        Word4 = 32'h55; Shamt4 = 5'd0; Start4 = 1'b1; Flush4 = 1'b1;
        @(posedge clk);
        #1 Start4 = 1'b0; Flush4 = 1'b0;
        @(negedge clk);
        check("flushBeatsStart", 64'(Done4), 64'd0);

        // Asynchronous reset mid-SHIFT
        @(negedge clk);
        Word4 = 32'h5; Shamt4 = 5'd20; ShiftRight4 = 1'b0; Start4 = 1'b1;
        @(posedge clk);
        #1 Start4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("asyncRstReady", 64'(Ready4), 64'd1);
        check("asyncRstDone", 64'(Done4), 64'd0);
        check("asyncRstResult", 64'(Result4), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runOp(32'h3, 5'd2, 1'b0, 1'b0, 2, 32'hC);

        repeat (3) @(negedge clk);
        check("sbDrained", 64'(sbQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish before bound");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "timeout");
    end

endmodule
